// File: rtl/mau_pkg.sv
// mau_pkg: shared types and constants for the load/store access unit.
// Holds the FSM state encoding, funct3 access codes and request legality helpers.
package mau_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'b00,
    ACCESS = 2'b01,
    MERGE  = 2'b10,
    RESP   = 2'b11
  } mauState;

  // funct3 access codes: low two bits give the size, bit 2 selects zero extension
  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  localparam logic [1:0] SZ_B = 2'b00;
  localparam logic [1:0] SZ_H = 2'b01;
  localparam logic [1:0] SZ_W = 2'b10;

  // Undefined codes are illegal; unsigned variants only make sense for loads
  function automatic logic isIllegal(input logic write, input logic [2:0] funct3);
    logic bad;
    case (funct3)
      F3_B, F3_H, F3_W: bad = 1'b0;
      F3_BU, F3_HU:     bad = write;
      default:          bad = 1'b1;
    endcase
    return bad;
  endfunction

  // Halfwords need an even offset, words need offset zero
  function automatic logic isMisaligned(input logic [2:0] funct3, input logic [1:0] offset);
    logic mis;
    case (funct3[1:0])
      SZ_H:    mis = offset[0];
      SZ_W:    mis = |offset;
      default: mis = 1'b0;
    endcase
    return mis;
  endfunction

endpackage

// File: rtl/mau_lane_align.sv
// mau_lane_align: combinational lane steering for the access unit.
// Extracts and extends load data from a memory word, and builds the merged
// word for sub-word stores. Halfword offsets use bit 1 only and word accesses
// ignore the offset, so misaligned addresses fall back to the aligned lane.
import mau_pkg::*;

module mau_lane_align (
  input  logic [1:0]  offset,
  input  logic [1:0]  size,
  input  logic        isSigned,
  input  logic [31:0] rdWord,
  input  logic [31:0] baseWord,
  input  logic [31:0] storeData,
  output logic [31:0] loadData,
  output logic [31:0] mergeData
);

  logic [7:0]  laneB;
  logic [15:0] laneH;

  // Lane select, extension and store merge
  always_comb begin
    // NOTE: every output of a combinational block gets a default first, so no path leaves it unassigned and no latch is inferred.
    laneB     = rdWord[{offset, 3'b000} +: 8];
    laneH     = rdWord[{offset[1], 4'b0000} +: 16];
    loadData  = rdWord;
    mergeData = baseWord;
    case (size)
      SZ_B: begin
        loadData = {{24{isSigned & laneB[7]}}, laneB};
        mergeData[{offset, 3'b000} +: 8] = storeData[7:0];
      end
      SZ_H: begin
        loadData = {{16{isSigned & laneH[15]}}, laneH};
        mergeData[{offset[1], 4'b0000} +: 16] = storeData[15:0];
      end
      default: begin
        loadData  = rdWord;
        mergeData = storeData;
      end
    endcase
  end

endmodule

// File: rtl/mem_access_unit.sv
// mem_access_unit: load/store initiator between execute and a word-addressed
// little-endian data memory. Sub-word stores are done as read-modify-write.
// Build option: define MAU_MISALIGN_TRAP_EN to turn misaligned halfword/word
// accesses into error responses; otherwise they are silently aligned down.
import mau_pkg::*;

module mem_access_unit #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_write,
  input  logic [2:0]        req_funct3,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              resp_valid,
  output logic [DATA_W-1:0] resp_rdata,
  output logic              resp_err,
  output logic [ADDR_W-1:0] mem_adr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              mem_write,
  input  logic [DATA_W-1:0] mem_rdata
);

  mauState           state, nextState;
  logic              writeQ;
  logic [2:0]        funct3Q;
  logic [ADDR_W-1:0] addrQ;
  logic [DATA_W-1:0] wdataQ;
  logic [DATA_W-1:0] mergeQ;
  logic [DATA_W-1:0] loadData;
  logic [DATA_W-1:0] mergeData;
  logic              reqErr;
  logic              subWordStore;

`ifdef MAU_MISALIGN_TRAP_EN
  assign reqErr = isIllegal(req_write, req_funct3) || isMisaligned(req_funct3, req_addr[1:0]);
`else
  assign reqErr = isIllegal(req_write, req_funct3);
`endif

  assign subWordStore = writeQ && (funct3Q[1:0] != SZ_W);
  assign req_ready    = (state == IDLE);
  assign mem_adr      = {addrQ[ADDR_W-1:2], 2'b00};

  mau_lane_align u_lane_align (
    .offset    (addrQ[1:0]),
    .size      (funct3Q[1:0]),
    .isSigned  (~funct3Q[2]),
    .rdWord    (mem_rdata),
    .baseWord  (mergeQ),
    .storeData (wdataQ),
    .loadData  (loadData),
    .mergeData (mergeData)
  );

  // State register; reset returns to IDLE at once, dropping any write in flight
  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: clocked state uses non-blocking assignments so every register samples pre-edge values.
    if (!rst_n) state <= IDLE;
    else        state <= nextState;
  end

  // Next-state and memory/response strobes decoded from the current state
  always_comb begin
    nextState  = state;
    resp_valid = 1'b0;
    mem_write  = 1'b0;
    mem_wdata  = '0;
    case (state)
      IDLE: begin
        if (req_valid) nextState = reqErr ? RESP : ACCESS;
      end
      ACCESS: begin
        if (subWordStore) begin
          nextState = MERGE;
        end else begin
          nextState = RESP;
          if (writeQ) begin
            mem_write = 1'b1;
            mem_wdata = wdataQ;
          end
        end
      end
      MERGE: begin
        mem_write = 1'b1;
        mem_wdata = mergeData;
        nextState = RESP;
      end
      RESP: begin
        resp_valid = 1'b1;
        nextState  = IDLE;
      end
      default: nextState = IDLE;
    endcase
  end

  // Request capture, load result and read-modify-write word capture
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      writeQ     <= 1'b0;
      funct3Q    <= '0;
      addrQ      <= '0;
      wdataQ     <= '0;
      mergeQ     <= '0;
      resp_rdata <= '0;
      resp_err   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (req_valid) begin
            writeQ     <= req_write;
            funct3Q    <= req_funct3;
            addrQ      <= req_addr;
            wdataQ     <= req_wdata;
            resp_rdata <= '0;
            resp_err   <= reqErr;
          end
        end
        ACCESS: begin
          if (!writeQ)          resp_rdata <= loadData;
          else if (subWordStore) mergeQ    <= mem_rdata;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: doc/mem_access_unit.md
# mem_access_unit

Load/store initiator between the core's execute stage and the word-addressed, little-endian data memory (32-bit, combinational read, write on rising clk edge, address LSBs ignored). Accepts one byte/halfword/word load or store per request, issues aligned word accesses, and performs read-modify-write for sub-word stores. Returns sign/zero-extended load data and an error flag through a single-cycle response pulse.

## Interface
Parameters:
- ADDR_W, 32, byte address width
- DATA_W, 32, data width; only 32 supported

Ports:
- clk  in  1  clock; all state updates on rising edge
- rst_n  in  1  asynchronous active-low reset
- req_valid  in  1  request present
- req_ready  out  1  unit idle, request accepted when req_valid&&req_ready
- req_write  in  1  1 = store, 0 = load
- req_funct3  in  3  000 b, 001 h, 010 w, 100 bu, 101 hu (loads only)
- req_addr  in  32  byte address
- req_wdata  in  32  store data, right-justified
- resp_valid  out  1  one-cycle completion pulse
- resp_rdata  out  32  extended load data; 0 for stores/errors
- resp_err  out  1  misaligned or illegal request, valid with resp_valid
- mem_adr  out  32  word address {addr[31:2],2'b00}
- mem_wdata  out  32  word written to memory
- mem_write  out  1  memory write enable
- mem_rdata  in  32  combinational read word for mem_adr

## Operation
- States: IDLE, ACCESS, MERGE, RESP.
- IDLE: req_ready=1; on accept latch write/funct3/addr/wdata, evaluate error -> RESP if error, else ACCESS.
- ACCESS: mem_adr driven from latched addr. Load: extract lane at addr[1:0], extend (b/h signed, bu/hu zero), register into resp_rdata -> RESP. sw: mem_write=1, mem_wdata=wdata -> RESP. sb/sh: capture mem_rdata into merge register -> MERGE.
- MERGE: mem_write=1, mem_wdata = captured word with byte (addr[1:0]) or halfword (addr[1]) replaced by wdata[7:0]/[15:0]; other lanes untouched -> RESP.
- RESP: resp_valid=1 for exactly one cycle -> IDLE. No response backpressure.
- Lane k = bits [8k+7:8k] at byte address offset k.
- Error: funct3 011/110/111, store with funct3[2]=1, or misalignment (see Configuration). Errors never assert mem_write; resp_rdata=0, resp_err=1.
- mem_write asserted only in ACCESS (sw) or MERGE (sb/sh); zero elsewhere.

## Timing
- Accept at edge T. Load/sw: resp_valid during cycle T+2. sb/sh: resp_valid during T+3. Error: resp_valid during T+1.
- req_ready low from T until the cycle after RESP; back-to-back throughput: load 3 cycles, sb/sh 4 cycles.
- Memory write occurs at edge closing ACCESS (sw) or MERGE (sb/sh).
- Reset values: state IDLE, req_ready=1, resp_valid=0, resp_rdata=0, resp_err=0, mem_write=0, mem_adr=0, mem_wdata=0.
- Reset mid-operation: immediate return to IDLE, mem_write deasserts asynchronously; no write if rst_n falls before the write edge; no response issued.
- req_* ignored outside IDLE.

## Configuration
- MAU_MISALIGN_TRAP_EN defined: h/hu/sh with addr[0]=1 or w/sw with addr[1:0]≠0 -> error response, no access.
- Undefined: misaligned addresses silently aligned down (halfword: addr[0] ignored; word: addr[1:0] ignored); resp_err only for illegal funct3.

## Structure
- Package mau_pkg: state enum, funct3 constants (F3_B, F3_H, F3_W, F3_BU, F3_HU).
- Sub-module mau_lane_align (combinational): load extract/extend and store merge from offset, size, signedness.

## Test plan
- Memory word @0x100 = 0x8899AABB; lb 0x101 -> resp_rdata 0xFFFFFFAA at T+2; lbu 0x101 -> 0x000000AA; lh 0x102 -> 0xFFFF8899.
- sb 0x102 wdata 0x12345677 onto 0x8899AABB -> word becomes 0x8877AABB, mem_write high exactly one cycle (MERGE), resp at T+3.
- sw 0x200 wdata 0xDEADBEEF -> single write, lw 0x200 returns 0xDEADBEEF.
- With MAU_MISALIGN_TRAP_EN: lw 0x203 -> resp_err=1, resp_rdata=0 at T+1, mem_write never high; without: returns word @0x200.
- funct3=011 -> resp_err=1 in either build.
- sh accepted then rst_n low during ACCESS -> no memory change, outputs at reset values, req_ready=1.
